// File: rtl/dac_out_ctrl.sv
// =============================================================================
// Module      : dac_out_ctrl
// Description : Buffers two's-complement samples in a small FIFO and streams
//               them to a parallel DAC as offset binary, one code every DIV
//               clocks, with a latch clock centred in the data eye.
//               Optional build macro: DAC_UFL_CNT_EN (saturating underflow count).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dac_out_ctrl #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    parameter int DIV   = 50
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dac_data,
    output logic          dac_clk,
    output logic          underflow
`ifdef DAC_UFL_CNT_EN
    ,
    output logic [15:0]   ufl_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] C_CNT_MAX    = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HALF_DIV   = CW'(DIV / 2);
    localparam logic [PW-1:0] C_HALF_DEPTH = PW'(DEPTH / 2);
    localparam logic [DW-1:0] C_MIDSCALE   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   r_dac_data;
    logic            r_dac_clk;
    logic            r_underflow;

    logic            w_empty;
    logic            w_full;
    logic [PW-1:0]   w_level;
    logic            w_tick;
    logic            w_flush;
    logic            w_pop;
    logic            w_ufl;
    logic            w_wr;
    logic [DW-1:0]   w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_level = r_wptr - r_rptr;
    assign w_tick  = (r_state != S_IDLE) && (r_cnt == C_CNT_MAX);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // A flush cycle drops any concurrent write; the producer learns via en.
    assign w_wr    = din_valid && !w_full && !w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_pop       = 1'b0;
        w_ufl       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_PRIME;
            end
            S_PRIME: begin
                if (!en) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tick && (w_level >= C_HALF_DEPTH)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (w_empty) w_ufl = 1'b1;
                    else         w_pop = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        if ((r_state == S_IDLE) || w_flush || (r_cnt == C_CNT_MAX)) w_cnt_nxt = '0;
        else                                                        w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_dac_clk   <= 1'b0;
            r_underflow <= 1'b0;
            r_dac_data  <= C_MIDSCALE;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_dac_clk   <= (w_cnt_nxt >= C_HALF_DIV);
            r_underflow <= w_ufl;
            if (w_flush) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_dac_data <= C_MIDSCALE;
            end else begin
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                if (w_pop) begin
                    r_rptr     <= r_rptr + 1'b1;
                    r_dac_data <= {~w_head[DW-1], w_head[DW-2:0]};
                end
            end
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
    end

`ifdef DAC_UFL_CNT_EN
    logic [15:0] r_ufl_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ufl_cnt <= '0;
        end else if (w_ufl && (r_ufl_cnt != 16'hFFFF)) begin
            r_ufl_cnt <= r_ufl_cnt + 16'd1;
        end
    end

    assign ufl_cnt = r_ufl_cnt;
`endif

    assign din_ready = !w_full;
    assign dac_data  = r_dac_data;
    assign dac_clk   = r_dac_clk;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_dac_out_ctrl.sv
// =============================================================================
// Module      : tb_dac_out_ctrl
// Description : Randomized self-checking bench for dac_out_ctrl against a
//               queue-based reference model of the streaming rules.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dac_out_ctrl;

    localparam int DW    = 10;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam logic [DW-1:0] MID = 10'h200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] dac_data;
    logic          dac_clk;
    logic          underflow;
`ifdef DAC_UFL_CNT_EN
    logic [15:0]   ufl_cnt;
`endif

    dac_out_ctrl #(.DW(DW), .DEPTH(DEPTH), .DIV(DIV)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dac_data  (dac_data),
        .dac_clk   (dac_clk),
        .underflow (underflow)
`ifdef DAC_UFL_CNT_EN
        ,
        .ufl_cnt   (ufl_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = waiting to prime, 2 = streaming.
    logic [DW-1:0] q[$];
    int            m_mode;
    int            m_phase;
    logic [DW-1:0] m_data;
    bit            m_clk;
    bit            m_ufl;
    int            m_ucnt;

    function automatic void model_reset();
        q.delete();
        m_mode  = 0;
        m_phase = 0;
        m_data  = MID;
        m_clk   = 0;
        m_ufl   = 0;
        m_ucnt  = 0;
    endfunction

    function automatic void model_step();
        bit            wr;
        logic [DW-1:0] d;
        wr    = din_valid && (q.size() < DEPTH);
        m_ufl = 0;
        if (m_mode != 0 && !en) begin
            q.delete();
            m_mode  = 0;
            m_phase = 0;
            m_data  = MID;
            m_clk   = 0;
        end else if (m_mode == 0) begin
            if (wr) q.push_back(din);
            if (en) m_mode = 1;
        end else begin
            if (m_phase == DIV - 1) begin
                if (m_mode == 1 && q.size() >= DEPTH / 2) begin
                    d      = q.pop_front();
                    m_data = d ^ 10'h200;
                    m_mode = 2;
                end else if (m_mode == 2) begin
                    if (q.size() > 0) begin
                        d      = q.pop_front();
                        m_data = d ^ 10'h200;
                    end else begin
                        m_ufl = 1;
                        if (m_ucnt < 65535) m_ucnt++;
                    end
                end
            end
            if (wr) q.push_back(din);
            m_phase = (m_phase + 1) % DIV;
            m_clk   = (m_phase >= DIV / 2);
        end
    endfunction

    task automatic check_outputs();
        check("din_ready", din_ready, (q.size() < DEPTH));
        check("dac_data",  dac_data,  m_data);
        check("dac_clk",   dac_clk,   m_clk);
        check("underflow", underflow, m_ufl);
`ifdef DAC_UFL_CNT_EN
        check("ufl_cnt",   ufl_cnt,   m_ucnt);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Random producer that honours the hold rule while stalled.
    task automatic drive_rand(input int pct);
        if (!(din_valid && !din_ready)) begin
            din_valid = ($urandom_range(99) < pct);
            din       = DW'($urandom);
        end
    endtask

    int ufl_seen;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Directed: three extreme codes through prime and run
        en = 1'b1;
        din_valid = 1'b1;
        din = 10'h000; cycle();
        din = 10'h1FF; cycle();
        din = 10'h200; cycle();
        din_valid = 1'b0;
        repeat (24) cycle();   // drains and then underflows

        // Directed: fill while idle, overflow attempts, then drain
        en = 1'b0;
        cycle();
        for (int k = 0; k < 6; ) begin
            din_valid = 1'b1;
            din       = DW'(10'h050 + k);
            if (din_ready) k++;
            cycle();
            if (k == 6) break;
            if (n_vec > 400) break;
        end
        repeat (3) cycle();
        en = 1'b1;
        repeat (16) cycle();
        din_valid = 1'b0;
        repeat (20) cycle();

        // Directed: drop en with words buffered, then re-enable
        en = 1'b0; cycle();
        din_valid = 1'b1;
        repeat (3) begin din = DW'($urandom); cycle(); end
        din_valid = 1'b0;
        en = 1'b1;
        repeat (12) cycle();
        en = 1'b0; cycle();
        en = 1'b1;
        repeat (12) cycle();

        // Randomized segments with en toggles
        for (int seg = 0; seg < 20; seg++) begin
            int pct;
            pct = $urandom_range(100);
            if ($urandom_range(3) == 0) en = ~en;
            for (int c = 0; c < 100; c++) begin
                drive_rand(pct);
                if ($urandom_range(199) == 0) en = ~en;
                cycle();
            end
        end

        // Asynchronous reset mid-stream
        en = 1'b1;
        din_valid = 1'b1;
        repeat (10) begin din = DW'($urandom); cycle(); end
        #2 rst_n = 1'b0;
        #1;
        check("rst_dac_data",  dac_data,  MID);
        check("rst_dac_clk",   dac_clk,   1'b0);
        check("rst_underflow", underflow, 1'b0);
        model_reset();
        din_valid = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Steady stream, one write per DIV clocks
        en = 1'b1;
        ufl_seen = 0;
        for (int s = 0; s < 1000 * DIV; s++) begin
            din_valid = (s % DIV == 0);
            din       = DW'($urandom);
            cycle();
            if (s > 4 * DIV && underflow) ufl_seen++;
        end
        check("steady_underflows", ufl_seen, 0);
        din_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
